// File: rtl/if_id_ctrl_pkg.sv
// Shared front-end definitions for the IF/ID sequencer: state encoding,
// PC width, flush counter width and the redirect payload.
package if_id_ctrl_pkg;

   localparam int unsigned PC_W        = 64;
   localparam int unsigned FLUSH_CNT_W = 3;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HOLD  = 2'd1,
      ST_MISS  = 2'd2,
      ST_FLUSH = 2'd3
   } fe_state_e;

   typedef struct packed {
      logic            vld;
      logic [PC_W-1:0] pc;
   } redirect_t;

endpackage

// File: rtl/if_id_ctrl_sat_counter.sv
// Saturating up-counter used for front-end stall performance monitoring.
//  clk, rst_n : clock, async active-low reset
//  inc        : count this cycle
//  cnt        : current count, sticks at all-ones
module if_id_ctrl_sat_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (inc && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/if_id_ctrl.sv
// IF/ID pipeline register sequencer: bubbles on icache miss, holds on decode
// backpressure, redirects fetch and flushes on branch mispredict, and counts
// front-end stall cycles.
//  icache_hit / dec_full / mispredict / mispred_pc : fetch, decode, execute inputs
//  if_id_stall, fetch_stall : combinational hold requests (same-cycle response)
//  if_id_valid              : registered decode qualifier
//  redirect_vld/redirect_pc : registered one-cycle fetch redirect
//  stall_cnt                : saturating count of stalled or bubble cycles
module if_id_ctrl
   import if_id_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             icache_hit,
   input  logic             dec_full,
   input  logic             mispredict,
   input  logic [63:0]      mispred_pc,
   output logic             if_id_stall,
   output logic             if_id_valid,
   output logic             fetch_stall,
   output logic             redirect_vld,
   output logic [63:0]      redirect_pc,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

   fe_state_e              state_q, state_d;
   logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic                   valid_q, valid_d;
   redirect_t              redir_q, redir_d;
   logic                   hold_ok_c;
   logic                   stall_inc_c;

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         flush_cnt_q <= '0;
         valid_q     <= 1'b0;
         redir_q     <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         valid_q     <= valid_d;
         redir_q     <= redir_d;
      end
   end

   // Next state; priority mispredict > dec_full > !icache_hit
   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      valid_d     = valid_q;
      redir_d     = redir_q;
      redir_d.vld = 1'b0;

      if (mispredict) begin
         // Entering or restarting a flush always reloads the bubble count
         state_d     = ST_FLUSH;
         flush_cnt_d = FLUSH_LOAD;
         valid_d     = 1'b0;
         redir_d.vld = 1'b1;
         redir_d.pc  = mispred_pc;
      end else if (state_q == ST_FLUSH) begin
         // Wrong-path bundles are discarded regardless of backpressure
         valid_d = 1'b0;
         if (flush_cnt_q == '0) begin
            state_d = ST_RUN;
         end else begin
            flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
         end
      end else if (dec_full) begin
         // Register holds whatever it has, real bundle or bubble
         state_d = ST_HOLD;
      end else if (!icache_hit) begin
         state_d = ST_MISS;
         valid_d = 1'b0;
      end else begin
         state_d = ST_RUN;
         valid_d = 1'b1;
      end
   end

   // Holds are suppressed under reset, during a flush and on a mispredict
   assign hold_ok_c   = rst_n && !mispredict && (state_q != ST_FLUSH);
   assign if_id_stall = hold_ok_c && dec_full;
   assign fetch_stall = hold_ok_c && (dec_full || !icache_hit);

   assign if_id_valid  = valid_q;
   assign redirect_vld = redir_q.vld;
   assign redirect_pc  = redir_q.pc;

   assign stall_inc_c = !valid_q || if_id_stall;

   if_id_ctrl_sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_inc_c),
      .cnt   (stall_cnt)
   );

endmodule

// File: tb/tb_if_id_ctrl.sv
// Directed bench for if_id_ctrl: a 32-bit counter instance and a 4-bit
// counter instance share the same stimulus.
module tb_if_id_ctrl;

   logic        clk;
   logic        rst_n;
   logic        icache_hit;
   logic        dec_full;
   logic        mispredict;
   logic [63:0] mispred_pc;

   logic        if_id_stall, if_id_valid, fetch_stall, redirect_vld;
   logic [63:0] redirect_pc;
   logic [31:0] stall_cnt;

   logic        if_id_stall4, if_id_valid4, fetch_stall4, redirect_vld4;
   logic [63:0] redirect_pc4;
   logic [3:0]  stall_cnt4;

   int n_vec;
   int n_err;

   if_id_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .icache_hit   (icache_hit),
      .dec_full     (dec_full),
      .mispredict   (mispredict),
      .mispred_pc   (mispred_pc),
      .if_id_stall  (if_id_stall),
      .if_id_valid  (if_id_valid),
      .fetch_stall  (fetch_stall),
      .redirect_vld (redirect_vld),
      .redirect_pc  (redirect_pc),
      .stall_cnt    (stall_cnt)
   );

   if_id_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut4 (
      .clk          (clk),
      .rst_n        (rst_n),
      .icache_hit   (icache_hit),
      .dec_full     (dec_full),
      .mispredict   (mispredict),
      .mispred_pc   (mispred_pc),
      .if_id_stall  (if_id_stall4),
      .if_id_valid  (if_id_valid4),
      .fetch_stall  (fetch_stall4),
      .redirect_vld (redirect_vld4),
      .redirect_pc  (redirect_pc4),
      .stall_cnt    (stall_cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec      = 0;
      n_err      = 0;
      rst_n      = 1'b0;
      icache_hit = 1'b0;
      dec_full   = 1'b0;
      mispredict = 1'b0;
      mispred_pc = 64'h0;

      // Reset values (fetch_stall must stay low under reset even with a miss)
      repeat (2) cyc();
      chk("rst_valid",    64'(if_id_valid), 64'h0);
      chk("rst_stall",    64'(if_id_stall), 64'h0);
      chk("rst_fstall",   64'(fetch_stall), 64'h0);
      chk("rst_rvld",     64'(redirect_vld), 64'h0);
      chk("rst_rpc",      redirect_pc, 64'h0);
      chk("rst_cnt",      64'(stall_cnt), 64'h0);

      // 1. Steady hits: bubble in cycle 0, valid from cycle 1, count 1
      rst_n      = 1'b1;
      icache_hit = 1'b1;
      #1;
      chk("t1_valid_c0", 64'(if_id_valid), 64'h0);
      for (int i = 1; i <= 5; i++) begin
         cyc();
         chk("t1_valid", 64'(if_id_valid), 64'h1);
         chk("t1_stall", 64'(if_id_stall), 64'h0);
         chk("t1_cnt",   64'(stall_cnt), 64'd1);
      end

      // 2. Backpressure for 3 cycles: same-cycle stall, bundle kept
      dec_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t2_stall",  64'(if_id_stall), 64'h1);
         chk("t2_fstall", 64'(fetch_stall), 64'h1);
         chk("t2_valid",  64'(if_id_valid), 64'h1);
         cyc();
      end
      dec_full = 1'b0;
      #1;
      chk("t2_stall_off",  64'(if_id_stall), 64'h0);
      chk("t2_fstall_off", 64'(fetch_stall), 64'h0);
      chk("t2_valid_kept", 64'(if_id_valid), 64'h1);
      chk("t2_cnt",        64'(stall_cnt), 64'd4);
      cyc();

      // 3. Four-cycle icache miss: four bubbles, then the hit is captured
      icache_hit = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t3_fstall", 64'(fetch_stall), 64'h1);
         chk("t3_stall",  64'(if_id_stall), 64'h0);
         cyc();
         chk("t3_valid",  64'(if_id_valid), 64'h0);
      end
      icache_hit = 1'b1;
      #1;
      chk("t3_fstall_off", 64'(fetch_stall), 64'h0);
      cyc();
      chk("t3_valid_hit", 64'(if_id_valid), 64'h1);
      chk("t3_cnt",       64'(stall_cnt), 64'd8);

      // 4. Mispredict: pulse next cycle, three bubble cycles, then valid
      mispredict = 1'b1;
      mispred_pc = 64'h0000_0000_0040_1000;
      #1;
      chk("t4_rvld_pre", 64'(redirect_vld), 64'h0);
      chk("t4_stall",    64'(if_id_stall), 64'h0);
      cyc();
      mispredict = 1'b0;
      mispred_pc = 64'hDEAD_BEEF_0000_0000;
      chk("t4_rvld",     64'(redirect_vld), 64'h1);
      chk("t4_rpc",      redirect_pc, 64'h0000_0000_0040_1000);
      chk("t4_valid_f1", 64'(if_id_valid), 64'h0);
      #1;
      chk("t4_fstall_f", 64'(fetch_stall), 64'h0);
      cyc();
      chk("t4_rvld_off", 64'(redirect_vld), 64'h0);
      chk("t4_rpc_hold", redirect_pc, 64'h0000_0000_0040_1000);
      chk("t4_valid_f2", 64'(if_id_valid), 64'h0);
      cyc();
      chk("t4_valid_r0", 64'(if_id_valid), 64'h0);
      cyc();
      chk("t4_valid_r1", 64'(if_id_valid), 64'h1);
      chk("t4_cnt",      64'(stall_cnt), 64'd11);

      // 5. Mispredict again during the flush, with backpressure
      mispredict = 1'b1;
      mispred_pc = 64'h1000;
      cyc();
      chk("t5_rvld1", 64'(redirect_vld), 64'h1);
      chk("t5_rpc1",  redirect_pc, 64'h1000);
      mispred_pc = 64'h2000;
      dec_full   = 1'b1;
      #1;
      chk("t5_stall_mp", 64'(if_id_stall), 64'h0);
      chk("t5_fstall_mp", 64'(fetch_stall), 64'h0);
      cyc();
      mispredict = 1'b0;
      chk("t5_rvld2", 64'(redirect_vld), 64'h1);
      chk("t5_rpc2",  redirect_pc, 64'h2000);
      #1;
      chk("t5_stall_f", 64'(if_id_stall), 64'h0);
      cyc();
      chk("t5_rvld_off", 64'(redirect_vld), 64'h0);
      chk("t5_valid_f",  64'(if_id_valid), 64'h0);
      chk("t5_stall_f2", 64'(if_id_stall), 64'h0);
      cyc();
      dec_full = 1'b0;
      #1;
      chk("t5_valid_r0", 64'(if_id_valid), 64'h0);
      cyc();
      chk("t5_valid_r1", 64'(if_id_valid), 64'h1);
      chk("t5_cnt",      64'(stall_cnt), 64'd15);
      chk("t5_cnt4",     64'(stall_cnt4), 64'hF);

      // 6. Twenty stall cycles: 4-bit counter sticks at F, 32-bit keeps counting
      dec_full = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cyc();
         chk("t6_cnt4_sat", 64'(stall_cnt4), 64'hF);
      end
      dec_full = 1'b0;
      #1;
      chk("t6_cnt", 64'(stall_cnt), 64'd35);
      chk("t6_valid_held", 64'(if_id_valid), 64'h1);

      // Reset in the middle of a flush abandons the redirect
      mispredict = 1'b1;
      mispred_pc = 64'h3000;
      cyc();
      mispredict = 1'b0;
      chk("t6_rvld", 64'(redirect_vld), 64'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 64'(if_id_valid), 64'h0);
      chk("t6_rst_rvld",  64'(redirect_vld), 64'h0);
      chk("t6_rst_rpc",   redirect_pc, 64'h0);
      chk("t6_rst_cnt",   64'(stall_cnt), 64'h0);
      chk("t6_rst_cnt4",  64'(stall_cnt4), 64'h0);
      chk("t6_rst_fstall", 64'(fetch_stall), 64'h0);
      cyc();
      rst_n = 1'b1;
      #1;
      chk("t6_post_valid0", 64'(if_id_valid), 64'h0);
      cyc();
      chk("t6_post_rvld",   64'(redirect_vld), 64'h0);
      chk("t6_post_valid1", 64'(if_id_valid), 64'h1);
      chk("t6_post_cnt",    64'(stall_cnt), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
